tim6_ctrl: RTL

// - Sequencing core of basic timer 6: prescaler, 16-bit up-counter, auto-reload, update-event (UEV) generation.
// - Consumes control fields from CR1/EGR/PSC/ARR/SR and the UIE bit from the DIER register.
// - Produces the counter value, the UIF status flag and the gated interrupt request for the NVIC.

---
 rtl/tim6_pkg.sv | 13 +
 rtl/tim6_if.sv | 34 +++
 rtl/tim6_prescaler.sv | 47 ++++
 rtl/tim6_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/tim6_pkg.sv
// Shared definitions for the basic timer 6 sequencing core.
package tim6_pkg;

    // Width of the counter, the ARR register and the PSC register.
    localparam int unsigned TIM6_CNT_W = 16;

    // Counter sequencer states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tim6_state_e;

endpackage : tim6_pkg

// File: rtl/tim6_if.sv
// Control and status bundle between the timer-6 register block and the counter core.
interface tim6_if #(
    parameter int unsigned CNT_W = tim6_pkg::TIM6_CNT_W
) ();

    logic             i_cen;
    logic             i_udis;
    logic             i_urs;
    logic             i_opm;
    logic             i_arpe;
    logic             i_ug;
    logic             i_uif_clr;
    logic             i_uie;
    logic [CNT_W-1:0] i_psc;
    logic [CNT_W-1:0] i_arr;
    logic [CNT_W-1:0] o_cnt;
    logic             o_uev;
    logic             o_uif;
    logic             o_irq;
    logic             o_cen_clr;

    // Register block side: drives control fields, observes counter status.
    modport master (
        output i_cen, i_udis, i_urs, i_opm, i_arpe, i_ug, i_uif_clr, i_uie, i_psc, i_arr,
        input  o_cnt, o_uev, o_uif, o_irq, o_cen_clr
    );

    // Timer core side.
    modport slave (
        input  i_cen, i_udis, i_urs, i_opm, i_arpe, i_ug, i_uif_clr, i_uie, i_psc, i_arr,
        output o_cnt, o_uev, o_uif, o_irq, o_cen_clr
    );

endinterface : tim6_if

// File: rtl/tim6_prescaler.sv
// Timer-6 prescaler: divides the kernel clock by (psc_shadow + 1) while enabled.
module tim6_prescaler
    import tim6_pkg::*;
#(
    parameter int unsigned CNT_W = TIM6_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_psc,
    output logic             o_tick
);

    logic [CNT_W-1:0] psc_cnt_q,    psc_cnt_d;
    logic [CNT_W-1:0] psc_shadow_q, psc_shadow_d;

    // Tick on the last count of each prescaler period; compare-then-clear keeps 0xFFFF in range.
    assign o_tick = i_en && (psc_cnt_q == psc_shadow_q);

    // Next-state for the prescaler counter and its shadow register.
    always_comb begin
        psc_cnt_d    = psc_cnt_q;
        psc_shadow_d = psc_shadow_q;
        if (i_clr) begin
            psc_cnt_d = '0;
        end else if (i_en) begin
            psc_cnt_d = o_tick ? '0 : psc_cnt_q + CNT_W'(1);
        end
        if (i_load) begin
            psc_shadow_d = i_psc;
        end
    end

    // Prescaler state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_cnt_q    <= '0;
            psc_shadow_q <= '0;
        end else begin
            psc_cnt_q    <= psc_cnt_d;
            psc_shadow_q <= psc_shadow_d;
        end
    end

endmodule : tim6_prescaler

// File: rtl/tim6_ctrl.sv
// Timer-6 sequencing core: run/idle FSM, 16-bit up-counter, auto-reload and update events.
module tim6_ctrl
    import tim6_pkg::*;
#(
    parameter int unsigned CNT_W = TIM6_CNT_W
) (
    input  logic  clk,
    input  logic  rst,
    tim6_if.slave bus
);

    tim6_state_e      state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] arr_shadow_q, arr_shadow_d;
    logic             uev_q,        uev_d;
    logic             uif_q,        uif_d;
    logic             cen_clr_q,    cen_clr_d;
    logic             opm_lock_q,   opm_lock_d;

    logic             run;
    logic             tick;
    logic [CNT_W-1:0] arr_act;
    logic             ovf;
    logic             uev;
    logic             opm_stop;

    assign run      = (state_q == ST_RUN);
    assign arr_act  = bus.i_arpe ? arr_shadow_q : bus.i_arr;
    // An auto-reload of 0 parks the counter at 0 without ever overflowing.
    assign ovf      = tick && (arr_act != '0) && (cnt_q == arr_act);
    // Overflow and UG coinciding still yield a single update event.
    assign uev      = !bus.i_udis && (ovf || bus.i_ug);
    assign opm_stop = ovf && !bus.i_udis && bus.i_opm;

    tim6_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_en   (run),
        .i_clr  (bus.i_ug),
        .i_load (uev),
        .i_psc  (bus.i_psc),
        .o_tick (tick)
    );

    // Next-state for the FSM, counter, ARR shadow and status flags.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        arr_shadow_d = arr_shadow_q;
        uev_d        = uev;
        cen_clr_d    = opm_stop;
        uif_d        = uif_q;
        opm_lock_d   = opm_lock_q;

        if (bus.i_ug) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = (arr_act == '0 || cnt_q == arr_act) ? '0 : cnt_q + CNT_W'(1);
        end

        if (uev) begin
            arr_shadow_d = bus.i_arr;
        end

        // A set request beats a same-cycle software clear; URS only masks the UG source.
        if ((ovf && !bus.i_udis) || (bus.i_ug && !bus.i_udis && !bus.i_urs)) begin
            uif_d = 1'b1;
        end else if (bus.i_uif_clr) begin
            uif_d = 1'b0;
        end

        // After a one-pulse stop, CEN must be seen low before the counter may restart.
        if (opm_stop) begin
            opm_lock_d = 1'b1;
        end else if (!bus.i_cen) begin
            opm_lock_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: if (bus.i_cen && !opm_lock_q) state_d = ST_RUN;
            ST_RUN:  if (opm_stop || !bus.i_cen)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Core state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            arr_shadow_q <= '0;
            uev_q        <= 1'b0;
            uif_q        <= 1'b0;
            cen_clr_q    <= 1'b0;
            opm_lock_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            arr_shadow_q <= arr_shadow_d;
            uev_q        <= uev_d;
            uif_q        <= uif_d;
            cen_clr_q    <= cen_clr_d;
            opm_lock_q   <= opm_lock_d;
        end
    end

    assign bus.o_cnt     = cnt_q;
    assign bus.o_uev     = uev_q;
    assign bus.o_uif     = uif_q;
    assign bus.o_irq     = uif_q & bus.i_uie;
    assign bus.o_cen_clr = cen_clr_q;

endmodule : tim6_ctrl
